// File: rtl/ddr2dbuf_ex_if.sv
// DDR-to-dbuf loader bus: config, two DDR beat streams, dbuf write port.
// slave is the loader side, master the scheduler/DDR/test side.
interface ddr2dbuf_ex_if #(
  parameter int DATA_W    = 16,
  parameter int BATCH     = 4,
  parameter int PE_NUM    = 32,
  parameter int BUF_DEPTH = 256,
  parameter int CNT_W     = 8
);
  localparam int DDR_W  = DATA_W * BATCH;
  localparam int ADDR_W = $clog2(BUF_DEPTH);

  logic              conf_valid;
  logic              conf_ready;
  logic [1:0]        conf_mode;
  logic [CNT_W-1:0]  conf_ch_num;
  logic [CNT_W-1:0]  conf_row_num;
  logic [CNT_W-1:0]  conf_pix_num;
  logic [ADDR_W-1:0] conf_base;
  logic [ADDR_W-1:0] conf_ch_stride;
  logic [ADDR_W-1:0] conf_row_stride;
  logic [PE_NUM-1:0] conf_mask;

  logic [DDR_W-1:0]  ddr1_data;
  logic              ddr1_valid;
  logic              ddr1_ready;
  logic [DDR_W-1:0]  ddr2_data;
  logic              ddr2_valid;
  logic              ddr2_ready;

  logic [DDR_W-1:0]  dbuf_wr_data;
  logic [ADDR_W-1:0] dbuf_wr_addr;
  logic [PE_NUM-1:0] dbuf_wr_en;

  modport slave (
    input  conf_valid, conf_mode,
    input  conf_ch_num, conf_row_num, conf_pix_num,
    input  conf_base, conf_ch_stride, conf_row_stride,
    input  conf_mask,
    input  ddr1_data, ddr1_valid,
    input  ddr2_data, ddr2_valid,
    output conf_ready, ddr1_ready, ddr2_ready,
    output dbuf_wr_data, dbuf_wr_addr, dbuf_wr_en
  );

  modport master (
    output conf_valid, conf_mode,
    output conf_ch_num, conf_row_num, conf_pix_num,
    output conf_base, conf_ch_stride, conf_row_stride,
    output conf_mask,
    output ddr1_data, ddr1_valid,
    output ddr2_data, ddr2_valid,
    input  conf_ready, ddr1_ready, ddr2_ready,
    input  dbuf_wr_data, dbuf_wr_addr, dbuf_wr_en
  );
endinterface

// File: rtl/ddr2dbuf_ex.sv
// DDR beat stream(s) to per-PE data buffer loader.
// FC / CONV / DEPOOL layouts with incremental address generation.
module ddr2dbuf_ex #(
  parameter int DATA_W    = 16,
  parameter int BATCH     = 4,
  parameter int PE_NUM    = 32,
  parameter int BUF_DEPTH = 256,
  parameter int CNT_W     = 8,
  localparam int DDR_W    = DATA_W * BATCH,
  localparam int ADDR_W   = $clog2(BUF_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  ddr2dbuf_ex_if.slave   io
);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN
  } state_e;

  localparam logic [1:0] M_FC     = 2'd0;
  localparam logic [1:0] M_CONV   = 2'd1;
  localparam logic [1:0] M_DEPOOL = 2'd2;
  localparam logic [1:0] M_NOP    = 2'd3;

  state_e            state_q, state_d;
  logic              nop_q, nop_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  ch_num_q, ch_num_d;
  logic [CNT_W-1:0]  pix_num_q, pix_num_d;
  logic [CNT_W-1:0]  row_num_q, row_num_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ch_str_q, ch_str_d;
  logic [ADDR_W-1:0] row_str_q, row_str_d;
  logic [PE_NUM-1:0] mask_q, mask_d;

  logic [CNT_W-1:0]  ch_q, ch_d;
  logic [CNT_W-1:0]  pix_q, pix_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] ch_off_q, ch_off_d;
  logic [ADDR_W-1:0] row_off_q, row_off_d;

  logic [PE_NUM-1:0] wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DDR_W-1:0]  wr_data_q, wr_data_d;

  logic              is_run, is_dp, fire;
  logic              ch_last, pix_last, row_last, layer_last;
  logic [ADDR_W-1:0] ch_step, pix_half, addr_cur;
  logic [3:0]        unit_sel;
  logic [PE_NUM-1:0] en_cur;
  logic [DDR_W-1:0]  keep_data, data_cur;
  logic              unused_keep_hi;

  assign is_run = (state_q == RUN);
  assign is_dp  = (mode_q == M_DEPOOL);

  // DEPOOL pairs one beat of each stream; each ready waits on the other valid.
  assign io.conf_ready = (state_q == IDLE);
  assign io.ddr1_ready = is_run && (!is_dp || io.ddr2_valid);
  assign io.ddr2_ready = is_run && is_dp && io.ddr1_valid;
  assign fire          = io.ddr1_valid && io.ddr1_ready;

  assign io.dbuf_wr_en   = wr_en_q;
  assign io.dbuf_wr_addr = wr_addr_q;
  assign io.dbuf_wr_data = wr_data_q;

  assign unused_keep_hi = ^io.ddr2_data[DDR_W-1:BATCH];

  assign ch_last    = (ch_q == ch_num_q);
  assign pix_last   = (pix_q == pix_num_q);
  assign row_last   = (row_q == row_num_q);
  assign layer_last = ch_last &&
                      ((mode_q == M_FC) || (pix_last && row_last));

  assign ch_step  = (mode_q == M_FC) ? ADDR_W'(1) : ch_str_q;
  assign pix_half = ADDR_W'(pix_q >> 1);
  assign addr_cur = base_q + ch_off_q + row_off_q + pix_half;

  assign unit_sel = 4'b0001 << {row_q[0], pix_q[0]};
  assign en_cur   = (mode_q == M_CONV)
                  ? (mask_q & {(PE_NUM/4){unit_sel}})
                  : mask_q;

  always_comb begin
    keep_data = '0;
    for (int i = 0; i < BATCH; i++) begin
      if (io.ddr2_data[i])
        keep_data[i*DATA_W +: DATA_W] = io.ddr1_data[i*DATA_W +: DATA_W];
    end
  end

  assign data_cur = is_dp ? keep_data : io.ddr1_data;

  always_comb begin
    state_d   = state_q;
    nop_d     = nop_q;
    mode_d    = mode_q;
    ch_num_d  = ch_num_q;
    pix_num_d = pix_num_q;
    row_num_d = row_num_q;
    base_d    = base_q;
    ch_str_d  = ch_str_q;
    row_str_d = row_str_q;
    mask_d    = mask_q;
    ch_d      = ch_q;
    pix_d     = pix_q;
    row_d     = row_q;
    ch_off_d  = ch_off_q;
    row_off_d = row_off_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (io.conf_valid) begin
          mode_d    = io.conf_mode;
          ch_num_d  = io.conf_ch_num;
          pix_num_d = io.conf_pix_num;
          row_num_d = io.conf_row_num;
          base_d    = io.conf_base;
          ch_str_d  = io.conf_ch_stride;
          row_str_d = io.conf_row_stride;
          mask_d    = io.conf_mask;
          ch_d      = '0;
          pix_d     = '0;
          row_d     = '0;
          ch_off_d  = '0;
          row_off_d = '0;
          // NOP holds DRAIN one extra cycle: a 2-cycle busy pulse.
          if (io.conf_mode == M_NOP) begin
            state_d = DRAIN;
            nop_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (fire) begin
          wr_en_d   = en_cur;
          wr_addr_d = addr_cur;
          wr_data_d = data_cur;
          if (!ch_last) begin
            ch_d     = ch_q + 1'b1;
            ch_off_d = ch_off_q + ch_step;
          end else begin
            ch_d     = '0;
            ch_off_d = '0;
            if (!pix_last) begin
              pix_d = pix_q + 1'b1;
            end else begin
              pix_d = '0;
              row_d = row_q + 1'b1;
              // row>>1 steps up only when leaving an odd row
              if (row_q[0])
                row_off_d = row_off_q + row_str_q;
            end
          end
          if (layer_last)
            state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (nop_q)
          nop_d = 1'b0;
        else
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      nop_q     <= 1'b0;
      mode_q    <= M_FC;
      ch_num_q  <= '0;
      pix_num_q <= '0;
      row_num_q <= '0;
      base_q    <= '0;
      ch_str_q  <= '0;
      row_str_q <= '0;
      mask_q    <= '0;
      ch_q      <= '0;
      pix_q     <= '0;
      row_q     <= '0;
      ch_off_q  <= '0;
      row_off_q <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      nop_q     <= nop_d;
      mode_q    <= mode_d;
      ch_num_q  <= ch_num_d;
      pix_num_q <= pix_num_d;
      row_num_q <= row_num_d;
      base_q    <= base_d;
      ch_str_q  <= ch_str_d;
      row_str_q <= row_str_d;
      mask_q    <= mask_d;
      ch_q      <= ch_d;
      pix_q     <= pix_d;
      row_q     <= row_d;
      ch_off_q  <= ch_off_d;
      row_off_q <= row_off_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_ddr2dbuf_ex.sv
// Bench for ddr2dbuf_ex: random beats vs. a loop-based write model.
// Directed FC/CONV/DEPOOL/wrap/NOP/reset cases plus random CONV runs.
module tb_ddr2dbuf_ex;
  localparam int DATA_W    = 16;
  localparam int BATCH     = 4;
  localparam int PE_NUM    = 32;
  localparam int BUF_DEPTH = 256;
  localparam int CNT_W     = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ddr2dbuf_ex_if #(
    .DATA_W(DATA_W), .BATCH(BATCH), .PE_NUM(PE_NUM),
    .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)
  ) dif ();

  ddr2dbuf_ex #(
    .DATA_W(DATA_W), .BATCH(BATCH), .PE_NUM(PE_NUM),
    .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(dif.slave)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] en;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  wr_t         obs[$];
  wr_t         expq[$];
  logic [63:0] d1q[$];
  logic [63:0] d2q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int mode, chn, pixn, rown, base, cs, rs;
  logic [31:0] mask;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    wr_t w;
    if (rst && dif.dbuf_wr_en != '0) begin
      w.addr = dif.dbuf_wr_addr;
      w.en   = dif.dbuf_wr_en;
      w.data = dif.dbuf_wr_data;
      w.cyc  = cyc;
      obs.push_back(w);
    end
  end

  function automatic int nbeats();
    if (mode == 0) return chn + 1;
    return (chn + 1) * (pixn + 1) * (rown + 1);
  endfunction

  task automatic gen_beats(input int n);
    d1q.delete();
    d2q.delete();
    for (int i = 0; i < n; i++) begin
      d1q.push_back({$urandom, $urandom});
      d2q.push_back({$urandom, $urandom});
    end
  endtask

  task automatic build_exp();
    wr_t w;
    int idx;
    int u;
    expq.delete();
    idx = 0;
    w.cyc = 0;
    if (mode == 0) begin
      for (int k = 0; k <= chn; k++) begin
        w.addr = 8'(base + k);
        w.en   = mask;
        w.data = d1q[k];
        if (w.en != 0) expq.push_back(w);
      end
    end else begin
      for (int r = 0; r <= rown; r++)
        for (int p = 0; p <= pixn; p++)
          for (int c = 0; c <= chn; c++) begin
            w.addr = 8'(base + c * cs + (r / 2) * rs + p / 2);
            u = (r % 2) * 2 + (p % 2);
            for (int pe = 0; pe < PE_NUM; pe++)
              w.en[pe] = mask[pe] && (mode == 2 || (pe % 4) == u);
            if (mode == 2) begin
              for (int i = 0; i < BATCH; i++)
                w.data[i*16 +: 16] = d2q[idx][i] ? d1q[idx][i*16 +: 16] : 16'h0;
            end else begin
              w.data = d1q[idx];
            end
            idx++;
            if (w.en != 0) expq.push_back(w);
          end
    end
  endtask

  task automatic send_conf();
    @(negedge clk);
    dif.conf_mode       = 2'(mode);
    dif.conf_ch_num     = 8'(chn);
    dif.conf_pix_num    = 8'(pixn);
    dif.conf_row_num    = 8'(rown);
    dif.conf_base       = 8'(base);
    dif.conf_ch_stride  = 8'(cs);
    dif.conf_row_stride = 8'(rs);
    dif.conf_mask       = mask;
    dif.conf_valid      = 1'b1;
    #1 chk("conf_ready", 64'(dif.conf_ready), 64'd1);
    @(posedge clk);
    #1 dif.conf_valid = 1'b0;
  endtask

  task automatic send_beat(input int i, input int gap, input bit glitch,
                           output bit ok);
    bit f;
    ok = 1'b0;
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      dif.ddr1_data  = d1q[i];
      dif.ddr2_data  = d2q[i];
      dif.ddr1_valid = ($urandom_range(99) >= gap);
      dif.ddr2_valid = (mode == 2) && ($urandom_range(99) >= gap);
      if (glitch) begin
        dif.conf_valid = 1'b1;
        dif.conf_mode  = 2'd3;
        dif.conf_base  = 8'h55;
      end
      #1;
      f = dif.ddr1_valid && dif.ddr1_ready &&
          (mode != 2 || (dif.ddr2_valid && dif.ddr2_ready));
      @(posedge clk);
      if (f) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic stall5();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      dif.ddr1_data  = d1q[0];
      dif.ddr1_valid = 1'b1;
      dif.ddr2_valid = 1'b0;
      #1;
      chk("stall_rdy1", 64'(dif.ddr1_ready), 64'd0);
      chk("stall_en", 64'(dif.dbuf_wr_en), 64'd0);
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nwr"}, 64'(obs.size()), 64'(expq.size()));
    for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
      chk({tag, "_addr"}, 64'(obs[i].addr), 64'(expq[i].addr));
      chk({tag, "_en"}, 64'(obs[i].en), 64'(expq[i].en));
      chk({tag, "_data"}, obs[i].data, expq[i].data);
    end
  endtask

  task automatic finish_layer(input string tag);
    int c;
    c = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      c++;
      dif.ddr1_valid = 1'b0;
      dif.ddr2_valid = 1'b0;
      dif.conf_valid = 1'b0;
      if (dif.conf_ready) break;
    end
    chk({tag, "_drain"}, 64'(c), 64'd2);
    compare(tag);
  endtask

  task automatic run_layer(input string tag, input int gap,
                           input bit glitch, input bit stall);
    bit ok;
    obs.delete();
    build_exp();
    send_conf();
    for (int i = 0; i < nbeats(); i++) begin
      if (stall && i == 0) stall5();
      send_beat(i, gap, glitch, ok);
      if (!ok) begin
        chk({tag, "_timeout"}, 64'd0, 64'd1);
        break;
      end
    end
    finish_layer(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int low;
    dif.conf_valid = 1'b0;
    dif.conf_mode = '0;
    dif.conf_ch_num = '0;
    dif.conf_pix_num = '0;
    dif.conf_row_num = '0;
    dif.conf_base = '0;
    dif.conf_ch_stride = '0;
    dif.conf_row_stride = '0;
    dif.conf_mask = '0;
    dif.ddr1_data = '0;
    dif.ddr1_valid = 1'b0;
    dif.ddr2_data = '0;
    dif.ddr2_valid = 1'b0;

    #23;
    chk("rst_conf_ready", 64'(dif.conf_ready), 64'd1);
    chk("rst_rdy1", 64'(dif.ddr1_ready), 64'd0);
    chk("rst_rdy2", 64'(dif.ddr2_ready), 64'd0);
    chk("rst_en", 64'(dif.dbuf_wr_en), 64'd0);
    chk("rst_addr", 64'(dif.dbuf_wr_addr), 64'd0);
    chk("rst_data", dif.dbuf_wr_data, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // FC, continuous stream, one write per cycle
    mode = 0; chn = 7; pixn = 0; rown = 0;
    base = 'h10; cs = 0; rs = 0; mask = 32'hFFFF_FFFF;
    gen_beats(nbeats());
    run_layer("fc", 0, 1'b0, 1'b0);
    for (int i = 1; i < obs.size(); i++)
      chk("fc_rate", 64'(obs[i].cyc - obs[0].cyc), 64'(i));

    // CONV directed
    mode = 1; chn = 1; pixn = 3; rown = 1;
    base = 0; cs = 16; rs = 8; mask = 32'h0000_000F;
    gen_beats(nbeats());
    run_layer("conv", 0, 1'b0, 1'b0);
    chk("conv_last_addr", 64'(obs.size() > 0 ? obs[obs.size()-1].addr : 8'h0), 64'd17);
    chk("conv_last_en", 64'(obs.size() > 0 ? obs[obs.size()-1].en : 32'h0), 64'h8);

    // DEPOOL directed with a ddr2 stall first
    mode = 2; chn = 0; pixn = 0; rown = 0;
    base = 'h20; cs = 0; rs = 0; mask = 32'hA5A5_0F0F;
    gen_beats(1);
    d1q[0] = 64'h0004_0003_0002_0001;
    d2q[0] = 64'h5;
    run_layer("depool", 0, 1'b0, 1'b1);
    chk("depool_data", obs.size() > 0 ? obs[0].data : 64'h0, 64'h0000_0003_0000_0001);
    chk("depool_en", 64'(obs.size() > 0 ? obs[0].en : 32'h0), 64'hA5A5_0F0F);

    // random CONV layers with valid gaps, 64 beats each
    for (int t = 0; t < 3; t++) begin
      mode = 1; chn = 3; pixn = 3; rown = 3;
      base = $urandom_range(255); cs = $urandom_range(255);
      rs = $urandom_range(255);
      mask = (t == 2) ? 32'h0 : $urandom;
      gen_beats(nbeats());
      run_layer("rconv", 40, 1'b0, 1'b0);
    end

    // random DEPOOL with gaps on both streams
    mode = 2; chn = 2; pixn = 2; rown = 2;
    base = $urandom_range(255); cs = $urandom_range(255);
    rs = $urandom_range(255); mask = $urandom;
    gen_beats(nbeats());
    run_layer("rdepool", 30, 1'b0, 1'b0);

    // FC address wrap, conf_valid held during the run
    mode = 0; chn = 3; pixn = 0; rown = 0;
    base = 'hFE; cs = 0; rs = 0; mask = $urandom | 32'h1;
    gen_beats(nbeats());
    run_layer("fcwrap", 0, 1'b1, 1'b0);
    chk("fcwrap_a2", 64'(obs.size() > 2 ? obs[2].addr : 8'hAA), 64'h00);

    // NOP: no beats, conf_ready low 2 cycles
    mode = 3; chn = 5; pixn = 0; rown = 0; mask = 32'hFFFF_FFFF;
    obs.delete();
    send_conf();
    low = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dif.conf_ready) break;
      low++;
    end
    chk("nop_low", 64'(low), 64'd2);
    chk("nop_nwr", 64'(obs.size()), 64'd0);

    // asynchronous reset mid-CONV after 5 beats
    mode = 1; chn = 3; pixn = 3; rown = 3;
    base = 3; cs = 5; rs = 7; mask = 32'hFFFF_FFFF;
    gen_beats(nbeats());
    send_conf();
    for (int i = 0; i < 5; i++) begin
      send_beat(i, 0, 1'b0, ok);
      if (!ok) chk("rstrun_timeout", 64'd0, 64'd1);
    end
    #2 rst = 1'b0;
    #1;
    chk("arst_conf_ready", 64'(dif.conf_ready), 64'd1);
    chk("arst_rdy1", 64'(dif.ddr1_ready), 64'd0);
    chk("arst_en", 64'(dif.dbuf_wr_en), 64'd0);
    chk("arst_addr", 64'(dif.dbuf_wr_addr), 64'd0);
    chk("arst_data", dif.dbuf_wr_data, 64'd0);
    @(negedge clk);
    dif.ddr1_valid = 1'b0;
    rst = 1'b1;

    mode = 0; chn = 5; pixn = 0; rown = 0;
    base = $urandom_range(255); mask = $urandom | 32'h2;
    gen_beats(nbeats());
    run_layer("fcpost", 20, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
